i2c_master_engine: RTL and testbench

- Byte-level I2C master PHY executing the 2-bit instruction set (START, STOP, READ_BYTE, WRITE_BYTE) issued by the ADC controller.
- Sits between the controller's instruction/enable/byte handshake and the open-drain SCL/SDA pads.
- Generates bit timing from a quarter-bit divider and honours slave clock stretching.
- Returns the received byte, the ACK status and a complete flag.

---
 rtl/i2c_master_engine_if.sv | 27 ++
 rtl/i2c_master_engine.sv | 181 ++++++++++++++++++
 tb/tb_i2c_master_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_engine_if.sv
// Controller handshake and open-drain pad signals of the byte-level I2C master engine.
// The master modport is the engine side; the slave modport is the controller/pad side.
interface i2c_master_engine_if;
   logic [1:0] instructionI2C;
   logic       enableI2C;
   logic [7:0] byteToSendI2C;
   logic [7:0] byteReceivedI2C;
   logic       ackReceived;
   logic       completeI2C;
   logic       scl_oe;
   logic       sda_oe;
   logic       scl_in;
   logic       sda_in;
   logic [2:0] dbg_state;

   // Handshake: enableI2C is a level request taken only in IDLE together with instructionI2C and
   // byteToSendI2C; completeI2C is the acknowledge, low on the cycle after acceptance, then high
   // until enableI2C is seen low (or for exactly one cycle if enableI2C already dropped).
   modport master (
      input  instructionI2C, enableI2C, byteToSendI2C, scl_in, sda_in,
      output byteReceivedI2C, ackReceived, completeI2C, scl_oe, sda_oe, dbg_state
   );
   modport slave (
      output instructionI2C, enableI2C, byteToSendI2C, scl_in, sda_in,
      input  byteReceivedI2C, ackReceived, completeI2C, scl_oe, sda_oe, dbg_state
   );
endinterface

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master PHY: START, STOP, READ_BYTE, WRITE_BYTE with quarter-bit timing
// and slave clock stretching. Line drive is open-drain (oe=1 pulls low).
module i2c_master_engine #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic                clk,
   input  logic                rst_n,
   i2c_master_engine_if.master bus
);
   localparam int unsigned      DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_STOP  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [1:0]       r_q, w_q_nxt;
   logic [3:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_tx, w_tx_nxt;
   logic [7:0]       r_rx_sh, w_rx_sh_nxt;
   logic [7:0]       r_rx, w_rx_nxt;
   logic             r_ack, w_ack_nxt;
   logic             r_complete, w_complete_nxt;
   logic             r_hold_scl, w_hold_scl_nxt;
   logic             r_hold_sda, w_hold_sda_nxt;
   logic             w_scl_oe, w_sda_oe;
   logic             w_in_op, w_stretch, w_wrap;

   // Line drive per state and quarter; IDLE/DONE keep whatever the last operation left.
   always_comb begin
      w_scl_oe = r_hold_scl;
      w_sda_oe = r_hold_sda;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_scl_oe = r_hold_scl;
            w_sda_oe = r_hold_sda;
         end
         S_START: begin
            w_scl_oe = (r_q == 2'd3);
            w_sda_oe = r_q[1];
         end
         S_STOP: begin
            w_scl_oe = (r_q == 2'd0);
            w_sda_oe = (r_q != 2'd3);
         end
         S_WRITE: begin
            w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
            w_sda_oe = (r_bit < 4'd8) && !r_tx[7];
         end
         S_READ: begin
            w_scl_oe = (r_q == 2'd0) || (r_q == 2'd3);
            w_sda_oe = (r_bit == 4'd8);
         end
         default: begin
            w_scl_oe = 1'b0;
            w_sda_oe = 1'b0;
         end
      endcase
   end

   assign w_in_op   = (r_state == S_START) || (r_state == S_STOP) ||
                      (r_state == S_WRITE) || (r_state == S_READ);
   assign w_stretch = w_in_op && (r_q == 2'd1) && !w_scl_oe && !bus.scl_in;
   assign w_wrap    = w_in_op && !w_stretch && (r_div == DIV_MAX);

   always_comb begin
      w_state_nxt    = r_state;
      w_div_nxt      = r_div;
      w_q_nxt        = r_q;
      w_bit_nxt      = r_bit;
      w_tx_nxt       = r_tx;
      w_rx_sh_nxt    = r_rx_sh;
      w_rx_nxt       = r_rx;
      w_ack_nxt      = r_ack;
      w_complete_nxt = r_complete;
      w_hold_scl_nxt = r_hold_scl;
      w_hold_sda_nxt = r_hold_sda;
      case (r_state)
         S_IDLE: begin
            w_complete_nxt = 1'b0;
            if (bus.enableI2C) begin
               w_div_nxt = '0;
               w_q_nxt   = 2'd0;
               w_bit_nxt = 4'd0;
               w_tx_nxt  = bus.byteToSendI2C;
               case (bus.instructionI2C)
                  2'd0:    w_state_nxt = S_START;
                  2'd1:    w_state_nxt = S_STOP;
                  2'd2:    w_state_nxt = S_READ;
                  default: w_state_nxt = S_WRITE;
               endcase
            end
         end
         S_START, S_STOP, S_WRITE, S_READ: begin
            if (r_bit > 4'd8) begin
               w_state_nxt    = S_IDLE;
               w_hold_scl_nxt = 1'b0;
               w_hold_sda_nxt = 1'b0;
            end else begin
               if (!w_stretch) w_div_nxt = w_wrap ? '0 : r_div + 1'b1;
               if (w_wrap) begin
                  w_q_nxt = r_q + 2'd1;
                  // Last clk of q2 is the sample point for both ACK and read data.
                  if (r_q == 2'd2) begin
                     if (r_state == S_WRITE && r_bit == 4'd8) w_ack_nxt = ~bus.sda_in;
                     if (r_state == S_READ && r_bit < 4'd8) w_rx_sh_nxt = {r_rx_sh[6:0], bus.sda_in};
                  end
                  if (r_q == 2'd3) begin
                     if (r_state == S_START || r_state == S_STOP || r_bit == 4'd8) begin
                        w_state_nxt    = S_DONE;
                        w_hold_scl_nxt = w_scl_oe;
                        w_hold_sda_nxt = w_sda_oe;
                        if (r_state == S_READ) w_rx_nxt = r_rx_sh;
                     end else begin
                        w_bit_nxt = r_bit + 4'd1;
                        if (r_state == S_WRITE) w_tx_nxt = {r_tx[6:0], 1'b0};
                     end
                  end
               end
            end
         end
         S_DONE: begin
            // First DONE cycle only raises complete, so a dropped enable still yields a one-cycle pulse.
            if (!r_complete) begin
               w_complete_nxt = 1'b1;
            end else if (!bus.enableI2C) begin
               w_state_nxt    = S_IDLE;
               w_complete_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_complete_nxt = 1'b0;
            w_hold_scl_nxt = 1'b0;
            w_hold_sda_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_q        <= 2'd0;
         r_bit      <= 4'd0;
         r_tx       <= 8'h00;
         r_rx_sh    <= 8'h00;
         r_rx       <= 8'h00;
         r_ack      <= 1'b0;
         r_complete <= 1'b0;
         r_hold_scl <= 1'b0;
         r_hold_sda <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div      <= w_div_nxt;
         r_q        <= w_q_nxt;
         r_bit      <= w_bit_nxt;
         r_tx       <= w_tx_nxt;
         r_rx_sh    <= w_rx_sh_nxt;
         r_rx       <= w_rx_nxt;
         r_ack      <= w_ack_nxt;
         r_complete <= w_complete_nxt;
         r_hold_scl <= w_hold_scl_nxt;
         r_hold_sda <= w_hold_sda_nxt;
      end
   end

   assign bus.scl_oe          = w_scl_oe;
   assign bus.sda_oe          = w_sda_oe;
   assign bus.completeI2C     = r_complete;
   assign bus.byteReceivedI2C = r_rx;
   assign bus.ackReceived     = r_ack;
   assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine with CLK_DIV=4: table of operations plus hand-written
// sequences for clock stretching, early enable drop and asynchronous reset mid-read.
module tb_i2c_master_engine;
   localparam int CLK_DIV = 4;
   localparam int T_SHORT = 1 + 4 * CLK_DIV;
   localparam int T_LONG  = 1 + 36 * CLK_DIV;
   localparam int TIMEOUT = 2000;

   typedef struct {
      logic [1:0] instr;
      logic [7:0] tx;
      int         slv_mode;
      logic [7:0] slv_byte;
      int         exp_cycles;
      int         nbits;
      logic [8:0] exp_bits;
      int         probe_a_n;
      logic [1:0] probe_a;
      int         probe_b_n;
      logic [1:0] probe_b;
      logic [1:0] exp_final;
      logic [7:0] exp_rx;
      logic       exp_ack;
      int         stretch_on;
      int         stretch_off;
   } vec_t;

   logic clk;
   logic rst_n;
   i2c_master_engine_if bus();

   logic       slv_scl_hold;
   int         slv_mode;
   logic [7:0] slv_byte;
   logic       slv_sda_low  = 1'b0;
   logic       slv_prev_scl = 1'b1;
   logic       slv_prev_en  = 1'b0;
   int         slv_rises    = 0;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  model_rx;
   logic [0:0]  exp_q[$];
   vec_t        vecs[7];

   i2c_master_engine #(.CLK_DIV(CLK_DIV)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Open-drain pads: a line is low if either side pulls it.
   assign bus.scl_in = ~bus.scl_oe & ~slv_scl_hold;
   assign bus.sda_in = ~bus.sda_oe & ~slv_sda_low;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic slave_bit(input int mode, input logic [7:0] b, input int rises);
      logic [7:0] t;
      t = b << rises;
      if (mode == 1) return (rises == 8);
      if (mode == 2) return (rises < 8) ? ~t[7] : 1'b0;
      return 1'b0;
   endfunction

   // Slave: counts SCL rises since the request, changes SDA only while SCL is low.
   always @(negedge clk) begin
      slv_prev_en  <= bus.enableI2C;
      slv_prev_scl <= bus.scl_in;
      if (bus.enableI2C && !slv_prev_en) slv_rises <= 0;
      else if (bus.scl_in && !slv_prev_scl) slv_rises <= slv_rises + 1;
      if (!bus.scl_in) slv_sda_low <= slave_bit(slv_mode, slv_byte, slv_rises);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] instr, input logic [7:0] tx, input int mode,
                               input logic [7:0] sb, input int cyc, input int nb,
                               input logic [8:0] bits, input int pa_n, input logic [1:0] pa,
                               input int pb_n, input logic [1:0] pb, input logic [1:0] fin,
                               input logic [7:0] rx, input logic ack);
      vec_t v;
      v.instr = instr;       v.tx = tx;           v.slv_mode = mode;   v.slv_byte = sb;
      v.exp_cycles = cyc;    v.nbits = nb;        v.exp_bits = bits;
      v.probe_a_n = pa_n;    v.probe_a = pa;      v.probe_b_n = pb_n;  v.probe_b = pb;
      v.exp_final = fin;     v.exp_rx = rx;       v.exp_ack = ack;
      v.stretch_on = -1;     v.stretch_off = -1;
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int   n;
      int   rises;
      logic prev_scl;
      logic done;
      logic [8:0] bits;
      exp_q.delete();
      bits = v.exp_bits;
      for (int i = 0; i < v.nbits; i++) exp_q.push_back(bits[8-i]);
      slv_mode = v.slv_mode;
      slv_byte = v.slv_byte;
      prev_scl = bus.scl_in;
      bus.instructionI2C = v.instr;
      bus.byteToSendI2C  = v.tx;
      bus.enableI2C      = 1'b1;
      step();
      check({tag, "_accept_complete"}, bus.completeI2C, 0);
      bus.byteToSendI2C  = 8'($urandom_range(0, 255));
      bus.instructionI2C = 2'($urandom_range(0, 3));
      n = 0;
      rises = 0;
      done = 1'b0;
      while (!done && n <= TIMEOUT) begin
         if (bus.scl_in && !prev_scl) begin
            rises++;
            if (exp_q.size() > 0) check({tag, "_sda_bit"}, bus.sda_in, exp_q.pop_front());
         end
         prev_scl = bus.scl_in;
         if (n == v.probe_a_n) check({tag, "_probe_a"}, {bus.scl_oe, bus.sda_oe}, v.probe_a);
         if (n == v.probe_b_n) check({tag, "_probe_b"}, {bus.scl_oe, bus.sda_oe}, v.probe_b);
         if (n == v.exp_cycles - 2) check({tag, "_rx_held"}, bus.byteReceivedI2C, model_rx);
         if (bus.completeI2C) begin
            done = 1'b1;
         end else begin
            if (n == v.stretch_on) slv_scl_hold = 1'b1;
            if (n == v.stretch_off) slv_scl_hold = 1'b0;
            step();
            n++;
         end
      end
      slv_scl_hold = 1'b0;
      check({tag, "_complete_cycle"}, n, v.exp_cycles);
      check({tag, "_scl_rises"}, rises, v.nbits);
      check({tag, "_final_lines"}, {bus.scl_oe, bus.sda_oe}, v.exp_final);
      check({tag, "_rx"}, bus.byteReceivedI2C, v.exp_rx);
      check({tag, "_ack"}, bus.ackReceived, v.exp_ack);
      model_rx = v.exp_rx;
      step();
      step();
      check({tag, "_complete_held"}, bus.completeI2C, 1);
      check({tag, "_lines_held"}, {bus.scl_oe, bus.sda_oe}, v.exp_final);
      bus.enableI2C = 1'b0;
      step();
      check({tag, "_complete_fall"}, bus.completeI2C, 0);
      check({tag, "_idle"}, bus.dbg_state, 0);
   endtask

   initial begin
      vec_t st;
      vec_t wv;
      int   n;
      int   first_hi;
      rst_n = 1'b0;
      bus.enableI2C = 1'b0;
      bus.instructionI2C = 2'd0;
      bus.byteToSendI2C = 8'h00;
      slv_mode = 0;
      slv_byte = 8'h00;
      slv_scl_hold = 1'b0;
      model_rx = 8'h00;
      step();
      step();
      check("reset_scl_oe", bus.scl_oe, 0);
      check("reset_sda_oe", bus.sda_oe, 0);
      check("reset_complete", bus.completeI2C, 0);
      check("reset_rx", bus.byteReceivedI2C, 0);
      check("reset_ack", bus.ackReceived, 0);
      check("reset_state", bus.dbg_state, 0);
      rst_n = 1'b1;
      step();

      vecs[0] = mk(2'd0, 8'h00, 0, 8'h00, T_SHORT, 0, 9'b000000000, 7, 2'b00, 8, 2'b01, 2'b11, 8'h00, 1'b0);
      vecs[1] = mk(2'd1, 8'h00, 0, 8'h00, T_SHORT, 1, 9'b000000000, 11, 2'b01, 12, 2'b00, 2'b00, 8'h00, 1'b0);
      vecs[2] = mk(2'd0, 8'h00, 0, 8'h00, T_SHORT, 0, 9'b000000000, 7, 2'b00, 8, 2'b01, 2'b11, 8'h00, 1'b0);
      vecs[3] = mk(2'd3, 8'h90, 1, 8'h00, T_LONG, 9, 9'b100100000, 0, 2'b10, 20, 2'b01, 2'b10, 8'h00, 1'b1);
      vecs[4] = mk(2'd3, 8'h55, 0, 8'h00, T_LONG, 9, 9'b010101011, 4, 2'b01, 132, 2'b00, 2'b10, 8'h00, 1'b0);
      vecs[5] = mk(2'd2, 8'h00, 2, 8'hA5, T_LONG, 9, 9'b101001010, 128, 2'b11, 132, 2'b01, 2'b11, 8'hA5, 1'b0);
      vecs[6] = mk(2'd1, 8'h00, 0, 8'h00, T_SHORT, 1, 9'b000000000, 11, 2'b01, 12, 2'b00, 2'b00, 8'hA5, 1'b0);
      for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Slave holds SCL low through the first 20 clks of q1 in bit 3 of a WRITE.
      st = mk(2'd0, 8'h00, 0, 8'h00, T_SHORT, 0, 9'b000000000, 7, 2'b00, 8, 2'b01, 2'b11, 8'hA5, 1'b0);
      run_op(st, "pre_stretch_start");
      wv = mk(2'd3, 8'h90, 1, 8'h00, T_LONG + 20, 9, 9'b100100000, 79, 2'b00, 80, 2'b10, 2'b10, 8'hA5, 1'b1);
      wv.stretch_on  = 51;
      wv.stretch_off = 72;
      run_op(wv, "stretch_write");

      // Enable dropped mid-START: complete must pulse for exactly one cycle.
      slv_mode = 0;
      bus.instructionI2C = 2'd0;
      bus.enableI2C = 1'b1;
      step();
      n = 0;
      first_hi = -1;
      while (first_hi < 0 && n < TIMEOUT) begin
         step();
         n++;
         if (n == 3) bus.enableI2C = 1'b0;
         if (bus.completeI2C) first_hi = n;
      end
      check("pulse_rise_cycle", first_hi, T_SHORT);
      step();
      check("pulse_fall", bus.completeI2C, 0);
      check("pulse_idle", bus.dbg_state, 0);

      // Asynchronous reset during bit 5 of a READ.
      slv_mode = 2;
      slv_byte = 8'h3C;
      bus.instructionI2C = 2'd2;
      bus.enableI2C = 1'b1;
      step();
      n = 0;
      while (n < 81) begin
         step();
         n++;
      end
      check("rst_pre_scl_oe", bus.scl_oe, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_scl_oe", bus.scl_oe, 0);
      check("rst_async_sda_oe", bus.sda_oe, 0);
      check("rst_async_complete", bus.completeI2C, 0);
      check("rst_async_rx", bus.byteReceivedI2C, 0);
      check("rst_async_ack", bus.ackReceived, 0);
      check("rst_async_state", bus.dbg_state, 0);
      bus.enableI2C = 1'b0;
      slv_mode = 0;
      step();
      step();
      rst_n = 1'b1;
      step();
      model_rx = 8'h00;
      st = mk(2'd0, 8'h00, 0, 8'h00, T_SHORT, 0, 9'b000000000, 7, 2'b00, 8, 2'b01, 2'b11, 8'h00, 1'b0);
      run_op(st, "post_reset_start");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
